serial_compare_accumulator: RTL and testbench

Consumer end of the bit-slice comparator interface. Accepts one per-bit compare result (gt, eq) per handshake, MSB first, framed by a last flag. Folds the stream into a single word-level verdict (gt / eq / lt) plus the bit count. Presents that verdict on a valid/ready output port, so magnitude comparison of arbitrary-width operands can be done bit-serially with one 1-bit comparator slice.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/serial_compare_accumulator.sv | 109 ++++++++++
 tb/tb_serial_compare_accumulator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and the bit-verdict merge used by the serial comparator
// accumulator. A future tree comparator can reuse next_verdict.
package cmp_pkg;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    V_EQ = 2'b00,
    V_GT = 2'b01,
    V_LT = 2'b10
  } verdict_t;

  // The first non-equal bit, MSB first, decides the word.
  // Illegal code gt=eq=1 counts as gt.
  function automatic verdict_t next_verdict(input logic     resolved,
                                            input verdict_t verdict,
                                            input logic     gt,
                                            input logic     eq);
    if (resolved) return verdict;
    if (gt)       return V_GT;
    if (eq)       return V_EQ;
    return V_LT;
  endfunction

endpackage

// File: rtl/serial_compare_accumulator.sv
// Folds an MSB-first stream of per-bit compare results into one word verdict
// (gt/eq/lt), with bit count, and hands it downstream over valid/ready.
module serial_compare_accumulator
  import cmp_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_gt,
  input  logic             in_eq,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  output logic [CNT_W-1:0] out_len,
  output logic             out_err,
  output logic             out_ovf
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  verdict_t         verdict;
  verdict_t         verdict_new;
  logic             resolved;
  logic             err;
  logic             err_new;
  logic             accept;
  logic             hit_max;
  logic             frame_end;

  assign accept      = in_valid && in_ready;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign hit_max     = (cnt_inc == CNT_W'(MAX_BITS));
  assign frame_end   = accept && (in_last || hit_max);
  assign verdict_new = next_verdict(resolved, verdict, in_gt, in_eq);
  assign err_new     = err | (in_gt & in_eq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (frame_end) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // in_ready is a function of state and reset only, never of in_valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = !reset;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      verdict  <= V_EQ;
      resolved <= 1'b0;
      err      <= 1'b0;
    end else if (state == HOLD && out_ready) begin
      cnt      <= '0;
      verdict  <= V_EQ;
      resolved <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      cnt      <= cnt_inc;
      verdict  <= verdict_new;
      resolved <= (verdict_new != V_EQ);
      err      <= err_new;
    end
  end

  // Result registers are written only at frame end and keep their value after handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_gt  <= 1'b0;
      out_eq  <= 1'b0;
      out_lt  <= 1'b0;
      out_len <= '0;
      out_err <= 1'b0;
      out_ovf <= 1'b0;
    end else if (frame_end) begin
      out_gt  <= (verdict_new == V_GT);
      out_eq  <= (verdict_new == V_EQ);
      out_lt  <= (verdict_new == V_LT);
      out_len <= cnt_inc;
      out_err <= err_new;
      out_ovf <= hit_max && !in_last;
    end
  end

endmodule

// File: tb/tb_serial_compare_accumulator.sv
// Bench for serial_compare_accumulator: directed scenarios plus random frames
// on a 32-bit and a 4-bit instance, checked against a frame-level model.
module tb_serial_compare_accumulator;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic in_valid, in_gt, in_eq, in_last, out_ready;

  logic       a_in_ready, a_out_valid, a_out_gt, a_out_eq, a_out_lt, a_out_err, a_out_ovf;
  logic [5:0] a_out_len;
  logic       b_in_ready, b_out_valid, b_out_gt, b_out_eq, b_out_lt, b_out_err, b_out_ovf;
  logic [2:0] b_out_len;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_compare_accumulator #(.MAX_BITS(32)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_gt(in_gt), .in_eq(in_eq), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .out_gt(a_out_gt), .out_eq(a_out_eq), .out_lt(a_out_lt),
    .out_len(a_out_len), .out_err(a_out_err), .out_ovf(a_out_ovf)
  );

  serial_compare_accumulator #(.MAX_BITS(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_gt(in_gt), .in_eq(in_eq), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .out_gt(b_out_gt), .out_eq(b_out_eq), .out_lt(b_out_lt),
    .out_len(b_out_len), .out_err(b_out_err), .out_ovf(b_out_ovf)
  );

  // Observed view of the selected instance: {valid, gt, eq, lt, err, ovf, len[5:0]}
  wire        in_ready = sel ? b_in_ready : a_in_ready;
  wire [11:0] obs = sel ?
    {b_out_valid, b_out_gt, b_out_eq, b_out_lt, b_out_err, b_out_ovf, 3'b000, b_out_len} :
    {a_out_valid, a_out_gt, a_out_eq, a_out_lt, a_out_err, a_out_ovf, a_out_len};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one bit at a negedge once in_ready is high; returns after the accepting edge.
  task automatic send_bit(input logic g, input logic e, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end
    in_valid = 1'b1; in_gt = g; in_eq = e; in_last = l;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_gt = 1'b0; in_eq = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_cmp++;
      if (obs !== 12'h000) begin
        n_bad++; $display("[TB] FAIL reset_outputs sel=%0d: got %h, expected 000", s, obs);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("[TB] FAIL reset_in_ready sel=%0d: got %0b, expected 0", s, in_ready);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL ready_after_reset: got %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0; out_ready = 1'b1;
    send_bit(0, 1, 0); send_bit(0, 1, 0); send_bit(1, 0, 0); send_bit(0, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b110000, 6'd4}) begin
      n_bad++; $display("[TB] FAIL basic_gt: got %h, expected %h", obs, {6'b110000, 6'd4});
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL basic_hold_ready: got %0b, expected 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || obs[11] !== 1'b0) begin
      n_bad++; $display("[TB] FAIL basic_release: ready=%0b valid=%0b, expected 1/0", in_ready, obs[11]);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(0, 1, (i == 7));
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b101000, 6'd8} || in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL b2b_eq: got %h ready=%0b, expected %h ready=0", obs, in_ready, {6'b101000, 6'd8});
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL b2b_gap: in_ready=%0b, expected 1 after one cycle", in_ready);
    end
    send_bit(0, 0, 0); send_bit(1, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b100100, 6'd2}) begin
      n_bad++; $display("[TB] FAIL b2b_lt: got %h, expected %h", obs, {6'b100100, 6'd2});
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [11:0] exp;
    sel = 1'b0; out_ready = 1'b0;
    exp = {6'b110000, 6'd2};
    send_bit(1, 0, 0); send_bit(0, 1, 1);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_gt = 1'($urandom); in_eq = 1'($urandom); in_last = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp || in_ready !== 1'b0) begin
        n_bad++; $display("[TB] FAIL hold_stable cyc=%0d: got %h ready=%0b, expected %h ready=0", i, obs, in_ready, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || obs[11] !== 1'b0) begin
      n_bad++; $display("[TB] FAIL hold_release: ready=%0b valid=%0b, expected 1/0", in_ready, obs[11]);
    end
    send_bit(0, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b100100, 6'd1}) begin
      n_bad++; $display("[TB] FAIL hold_no_count: got %h, expected %h", obs, {6'b100100, 6'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_ovf();
    sel = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(0, 1, 0);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b101001, 6'd4}) begin
      n_bad++; $display("[TB] FAIL ovf_eq: got %h, expected %h", obs, {6'b101001, 6'd4});
    end
    send_bit(1, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b110000, 6'd1}) begin
      n_bad++; $display("[TB] FAIL ovf_next_frame: got %h, expected %h", obs, {6'b110000, 6'd1});
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_err();
    sel = 1'b0; out_ready = 1'b1;
    send_bit(1, 1, 0); send_bit(0, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b110010, 6'd2}) begin
      n_bad++; $display("[TB] FAIL err_frame: got %h, expected %h", obs, {6'b110010, 6'd2});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0; out_ready = 1'b1;
    send_bit(0, 1, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    #1 in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 12'h000 || in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_mid: got %h ready=%0b, expected 000 ready=0", obs, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    send_bit(0, 0, 1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {6'b100100, 6'd1}) begin
      n_bad++; $display("[TB] FAIL reset_recover: got %h, expected %h", obs, {6'b100100, 6'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit g[40];
    bit e[40];
    int maxb, len, n, d;
    bit decided, err, ovf;
    logic [2:0] v;
    logic [11:0] exp;
    for (int f = 0; f < 40; f++) begin
      sel = 1'($urandom);
      maxb = sel ? 4 : 32;
      len = $urandom_range(maxb + 3, 1);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(3, 0) != 0) begin g[i] = 0; e[i] = 1; end
        else begin g[i] = 1'($urandom); e[i] = 1'($urandom); end
      end
      // Model: a frame is cut at maxb bits; the first non-equal bit decides.
      n = (len > maxb) ? maxb : len;
      ovf = (len > maxb);
      decided = 0; err = 0; v = 3'b010;
      for (int i = 0; i < n; i++) begin
        if (g[i] && e[i]) err = 1;
        if (!decided && g[i])       begin v = 3'b100; decided = 1; end
        else if (!decided && !e[i]) begin v = 3'b001; decided = 1; end
      end
      exp = {1'b1, v, err, ovf, 6'(n)};
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) send_bit(g[i], e[i], (i == n - 1) && !ovf);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("[TB] FAIL random_frame %0d sel=%0d: got %h, expected %h", f, sel, obs, exp);
      end
      d = $urandom_range(3, 0);
      repeat (d) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs[11] !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("[TB] FAIL random_release %0d: valid=%0b ready=%0b, expected 0/1", f, obs[11], in_ready);
      end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_ovf();
    test_err();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
